// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit (and future receive) path.
//   parity_e   - parity_mode encodings (2'b11 is not listed and behaves as none)
//   tx_state_e - transmitter FSM states
//   frame_bits - number of bit periods in one frame for a given configuration
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b01,
    PARITY_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int unsigned frame_bits(int unsigned data_bits,
                                             logic parity_en, logic two_stop);
    return 1 + data_bits + (parity_en ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// uart_tx_framed_if: character handshake between the producer (CPU I/O logic)
// and the UART transmitter FIFO.
//   data_in       - character to queue
//   data_in_valid - producer has a character
//   data_in_ready - transmitter can accept (FIFO not full)
interface uart_tx_framed_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;

  modport master (output data_in, output data_in_valid, input data_in_ready);
  modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous single-clock FIFO, DEPTH a power of two >= 2.
//   clk, reset     - clock, synchronous active-high reset (flushes contents)
//   push, wdata    - write; ignored while full
//   pop, rdata     - read; rdata shows the head combinationally, pop ignored while empty
//   full, empty    - status
//   count          - entries held
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: buffered UART transmitter with runtime parity / stop-bit
// selection. Characters queue in a FIFO and go out back-to-back.
//   clk, reset   - clock, synchronous active-high reset
//   in_if        - character handshake (slave side)
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none; latched per frame
//   two_stop     - 1: two stop bits; latched per frame
//   serial_out   - TX line (registered, idle high)
//   busy         - a frame is on the line
//   fifo_count   - entries queued
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_tx_framed_if.slave                 in_if,
  input  logic [1:0]                      parity_mode,
  input  logic                            two_stop,
  output logic                            serial_out,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

  tx_state_e            state, state_n;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg, head;
  logic                 par_en_q, par_bit_q, two_stop_q;
  logic                 full, empty, pop, tx_n, tick;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.data_in_valid),
    .wdata (in_if.data_in),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign in_if.data_in_ready = !full;
  assign busy = (state != IDLE);
  assign tick = (cnt == CW'(SYMBOL_EDGE_TIME - 1));

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_n;

  // tx_n is the line level for the cycle after this edge, so serial_out is a
  // plain flop fed only by state.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = serial_out;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop = 1'b1; state_n = START; tx_n = 1'b0;
        end
      end
      START:
        if (tick) begin
          state_n = DATA; tx_n = shreg[0];
        end
      DATA:
        if (tick) begin
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_n = PARITY; tx_n = par_bit_q;
            end else begin
              state_n = STOP; tx_n = 1'b1;
            end
          end else begin
            tx_n = shreg[1];  // shreg shifts at this same edge
          end
        end
      PARITY:
        if (tick) begin
          state_n = STOP; tx_n = 1'b1;
        end
      STOP:
        if (tick && (stop_idx == two_stop_q)) begin
          if (!empty) begin
            pop = 1'b1; state_n = START; tx_n = 1'b0;
          end else begin
            state_n = IDLE; tx_n = 1'b1;
          end
        end
      default: begin
        state_n = IDLE; tx_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      serial_out <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      serial_out <= tx_n;
      // Bit-period counter restarts on every pop so periods are never cut short.
      if (pop || state == IDLE || tick) cnt <= '0;
      else                              cnt <= cnt + CW'(1);
      if (pop) begin
        shreg      <= head;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        par_en_q   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
        par_bit_q  <= (^head) ^ (parity_mode == PARITY_ODD);
        two_stop_q <= two_stop;
      end else if (tick) begin
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 4'd1;
        end
        if (state == STOP) stop_idx <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: directed bench for uart_tx_framed at 10 cycles/bit.
// dut0: 8 data bits, 4-entry FIFO, watched by a frame monitor fed from a
// scoreboard queue. dut1: 5 data bits, checked inline.
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int SET = 10;

  typedef struct {
    logic [15:0] bits;
    int          len;
    bit          b2b;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_framed_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framed_if #(.DATA_BITS(5)) if1 ();

  logic [1:0] pm0 = 2'b00, pm1 = 2'b00;
  logic       ts0 = 1'b0, ts1 = 1'b0;
  logic       so0, so1, bz0, bz1;
  logic [2:0] fc0;
  logic [3:0] fc1;

  uart_tx_framed #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                   .DATA_BITS(8), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .in_if(if0.slave), .parity_mode(pm0),
    .two_stop(ts0), .serial_out(so0), .busy(bz0), .fifo_count(fc0));

  uart_tx_framed #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                   .DATA_BITS(5), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .reset(reset), .in_if(if1.slave), .parity_mode(pm1),
    .two_stop(ts1), .serial_out(so1), .busy(bz1), .fifo_count(fc1));

  frame_t sb[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  bit mon_abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame, one entry per bit period.
  function automatic frame_t mk(input int nbits, input logic [8:0] d,
                                input logic [1:0] pm, input logic ts, input bit b2b);
    frame_t f;
    int p = 0;
    logic x = 1'b0;
    f.bits = '0;
    f.bits[p] = 1'b0; p++;
    for (int i = 0; i < nbits; i++) begin
      f.bits[p] = d[i]; x = x ^ d[i]; p++;
    end
    if (pm == 2'b01) begin f.bits[p] = x;  p++; end
    if (pm == 2'b10) begin f.bits[p] = ~x; p++; end
    f.bits[p] = 1'b1; p++;
    if (ts) begin f.bits[p] = 1'b1; p++; end
    f.len = p;
    f.b2b = b2b;
    return f;
  endfunction

  // Frame monitor for dut0: every cycle of every frame compared to the
  // scoreboard entry; b2b entries must start the cycle the previous one ended.
  initial begin : mon
    frame_t f;
    int st;
    int last_end;
    bit aborted;
    last_end = -1000;
    forever begin
      @(negedge clk);
      if (mon_abort || reset || so0 !== 1'b0) continue;
      st = cyc;
      chk("frame_expected", (sb.size() != 0), 1);
      if (sb.size() == 0) begin
        for (int w = 0; w < 2000 && so0 === 1'b0; w++) @(negedge clk);
        continue;
      end
      f = sb.pop_front();
      if (f.b2b) chk("b2b_gap", st - last_end, 0);
      aborted = 1'b0;
      for (int i = 0; i < f.len * SET; i++) begin
        if (i > 0) @(negedge clk);
        if (mon_abort) begin aborted = 1'b1; break; end
        chk($sformatf("line_bit%0d_cyc%0d", i / SET, i % SET), so0, f.bits[i / SET]);
        if (i % SET == 5) chk($sformatf("busy_bit%0d", i / SET), bz0, 1);
      end
      if (!aborted) last_end = st + f.len * SET;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push0(input logic [7:0] d);
    @(negedge clk);
    if0.data_in = d; if0.data_in_valid = 1'b1;
    @(posedge clk);
    #1 if0.data_in_valid = 1'b0;
  endtask

  task automatic busy_run(output int n);
    int w;
    w = 0; n = 0;
    @(negedge clk);
    while (bz0 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    while (bz0 === 1'b1 && n < 2000) begin n++; @(negedge clk); end
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end
    while ((bz0 !== 1'b0 || fc0 !== 3'd0) && w < bound);
    chk("idle_reached", bz0, 0);
  endtask

  initial begin : stim
    int n;
    int idx, t_first, t_last, lows, busys;
    bit stall_seen, rdy;
    logic [7:0] vals [6];
    logic [1:0] t2_pm [3];
    logic       t2_ts [3];
    int         t2_len [3];
    frame_t f;

    vals   = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    t2_pm  = '{2'b01, 2'b10, 2'b10};
    t2_ts  = '{1'b0, 1'b0, 1'b1};
    t2_len = '{110, 110, 120};

    if0.data_in = '0; if0.data_in_valid = 1'b0;
    if1.data_in = '0; if1.data_in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", so0, 1);
    chk("rst_busy", bz0, 0);
    chk("rst_count", fc0, 0);
    chk("rst_ready", if0.data_in_ready, 1);
    chk("rst_line_d1", so1, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0xA5: latency and frame length
    sb.push_back(mk(8, 9'h0A5, 2'b00, 1'b0, 1'b0));
    push0(8'hA5);
    @(negedge clk);
    chk("lat_count_after_push", fc0, 1);
    chk("lat_busy_before_pop", bz0, 0);
    chk("lat_line_before_pop", so0, 1);
    @(negedge clk);
    chk("lat_busy_at_pop", bz0, 1);
    chk("lat_line_at_pop", so0, 0);
    chk("lat_count_at_pop", fc0, 0);
    n = 1;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      if (bz0 !== 1'b1) break;
      n++;
    end
    chk("busy_len_8n1", n, 100);
    chk("idle_line_8n1", so0, 1);

    // 0x07 with even / odd / odd+two_stop
    for (int t = 0; t < 3; t++) begin
      repeat (3) @(negedge clk);
      pm0 = t2_pm[t]; ts0 = t2_ts[t];
      sb.push_back(mk(8, 9'h007, t2_pm[t], t2_ts[t], 1'b0));
      push0(8'h07);
      busy_run(n);
      chk($sformatf("busy_len_07_cfg%0d", t), n, t2_len[t]);
    end
    pm0 = 2'b00; ts0 = 1'b0;
    repeat (5) @(negedge clk);

    // FIFO fill: valid held with 0x11..0x16
    idx = 0; t_first = 0; t_last = 0; stall_seen = 1'b0;
    for (int c = 0; c < 400 && idx < 6; c++) begin
      @(negedge clk);
      if0.data_in = vals[idx]; if0.data_in_valid = 1'b1;
      rdy = if0.data_in_ready;
      if (!rdy && !stall_seen) begin
        stall_seen = 1'b1;
        chk("stall_count", fc0, 4);
        chk("stall_accepted", idx, 5);
      end
      @(posedge clk);
      if (rdy) begin
        sb.push_back(mk(8, {1'b0, vals[idx]}, 2'b00, 1'b0, idx > 0));
        if (idx == 0) t_first = cyc;
        if (idx == 5) t_last = cyc;
        idx++;
      end
    end
    #1 if0.data_in_valid = 1'b0;
    chk("stall_seen", stall_seen, 1);
    chk("accept6_delay", t_last - t_first, 102);
    wait_idle(1000);
    chk("fifo_drained", sb.size(), 0);
    repeat (5) @(negedge clk);

    // Parity change mid-frame takes effect on the next pop only
    pm0 = 2'b00;
    sb.push_back(mk(8, 9'h055, 2'b00, 1'b0, 1'b0));
    sb.push_back(mk(8, 9'h00E, 2'b01, 1'b0, 1'b1));
    @(negedge clk);
    if0.data_in = 8'h55; if0.data_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.data_in = 8'h0E;
    @(posedge clk);          // first pop happens at this edge
    #1 if0.data_in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 pm0 = 2'b01;
    wait_idle(500);
    chk("parity_change_drained", sb.size(), 0);
    pm0 = 2'b00;
    repeat (5) @(negedge clk);

    // Reset during data bit 3 with two entries queued
    sb.push_back(mk(8, 9'h03C, 2'b00, 1'b0, 1'b0));
    sb.push_back(mk(8, 9'h041, 2'b00, 1'b0, 1'b1));
    sb.push_back(mk(8, 9'h042, 2'b00, 1'b0, 1'b1));
    @(negedge clk);
    if0.data_in = 8'h3C; if0.data_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); if0.data_in = 8'h41;
    @(posedge clk);          // frame starts here
    @(negedge clk); if0.data_in = 8'h42;
    @(posedge clk);
    #1 if0.data_in_valid = 1'b0;
    repeat (43) @(posedge clk);
    @(negedge clk);
    chk("queued_before_reset", fc0, 2);
    chk("busy_before_reset", bz0, 1);
    mon_abort = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_line", so0, 1);
    chk("midrst_busy", bz0, 0);
    chk("midrst_count", fc0, 0);
    chk("midrst_ready", if0.data_in_ready, 1);
    reset = 1'b0;
    sb.delete();
    lows = 0; busys = 0;
    repeat (300) begin
      @(negedge clk);
      if (so0 !== 1'b1) lows++;
      if (bz0 !== 1'b0) busys++;
    end
    chk("post_rst_line_low_cycles", lows, 0);
    chk("post_rst_busy_cycles", busys, 0);
    mon_abort = 1'b0;

    // dut1: 5 data bits, 0x1F, two stop bits, no parity
    pm1 = 2'b00; ts1 = 1'b1;
    f = mk(5, 9'h01F, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    if1.data_in = 5'h1F; if1.data_in_valid = 1'b1;
    @(posedge clk);
    #1 if1.data_in_valid = 1'b0;
    @(posedge clk);          // pop edge
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk($sformatf("d5_bit%0d_cyc%0d", i / SET, i % SET), so1, f.bits[i / SET]);
      if (i == 0 || i == 79) chk($sformatf("d5_busy_cyc%0d", i), bz1, 1);
    end
    @(negedge clk);
    chk("d5_busy_end", bz1, 0);
    chk("d5_line_end", so1, 1);

    repeat (20) @(negedge clk);
    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised, buffered UART transmitter with configurable data width, runtime-selectable parity and stop-bit count, and an input FIFO. It sits between the CPU's memory-mapped I/O logic and the serial pin. The CPU can queue several characters without polling per character. Frames are transmitted back-to-back while the FIFO holds data.

## Interface
- CLOCK_FREQ, 125_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate. SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE is the integer number of cycles per bit.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 8: input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1: clock. reset, synchronous, active-high; clock clk.
- reset  in  1: synchronous, active-high.
- data_in  in  DATA_BITS: character to queue.
- data_in_valid  in  1: producer has a character.
- data_in_ready  out  1: FIFO not full.
- parity_mode  in  2: 00 none, 01 even, 10 odd, 11 treated as none.
- two_stop  in  1: 1 selects two stop bits, 0 selects one.
- serial_out  out  1: TX line, idle high.
- busy  out  1: a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH+1): entries queued.

## Operation
- Push occurs at a clk edge where data_in_valid && data_in_ready. data_in_ready = !full; it does not depend on data_in_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the head and latch the character, parity_mode and two_stop. Go to START. Otherwise hold serial_out = 1.
- START: drive 0 for one bit period, then go to DATA.
- DATA: drive the data LSB first, DATA_BITS periods. Then go to PARITY if parity is enabled, else STOP.
- PARITY: even mode sends the XOR of the data bits. Odd mode sends its inverse. One period, then STOP.
- STOP: drive 1 for 1 or 2 periods, as latched.
- End of the last stop period:
  - FIFO non-empty: pop and enter START at that same edge, with no idle cycle.
  - Otherwise: go to IDLE.
- Frame length = 1 + DATA_BITS + (parity ? 1 : 0) + (two_stop ? 2 : 1) bit periods, each exactly SYMBOL_EDGE_TIME cycles.
- The bit-period counter restarts at 0 on every pop. Bit periods never shorten or stretch.
- Changes to parity_mode or two_stop during a frame have no effect until the next pop.
- busy = (state != IDLE).
- Simultaneous push and pop: fifo_count unchanged. Pushes never occur while full.

## Timing
- After any reset edge, regardless of prior state:
  - serial_out = 1, busy = 0, fifo_count = 0, data_in_ready = 1.
  - The FIFO is flushed. Any frame in progress is abandoned immediately and the line returns high.
- Latency, with the FSM in IDLE and the FIFO empty:
  - Handshake at edge k.
  - Pop at edge k+1. serial_out = 0 and busy = 1 from edge k+1.
- fifo_count and data_in_ready update at the edge of the push or pop. They are visible in the following cycle.
- serial_out comes directly from a register, with no combinational path from the inputs.

## Structure
- Shared package uart_pkg holds:
  - the parity_mode encodings (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - the FSM state enum;
  - the helper that computes frame length.
- Sub-module uart_tx_fifo: a synchronous single-clock FIFO parametrised by WIDTH and DEPTH, with push/pop and full/empty/count outputs. It is reusable for the receive side.
- Top level contains the FSM, the bit-period counter, the bit index counter and the shift register.

## Test plan
Bench parameters: CLOCK_FREQ = 1_000_000, BAUD_RATE = 100_000, so 10 cycles/bit.
- 8N1, push 0xA5 while idle -> line reads 0, 1,0,1,0,0,1,0,1, 1. The frame lasts 100 cycles and busy is high for exactly 100 cycles.
- Push 0x07 three times with different settings:
  - even parity, one stop -> parity bit 1;
  - odd parity, one stop -> parity bit 0;
  - odd parity, two_stop -> parity bit 0 and a 120-cycle frame.
- FIFO_DEPTH = 4, valid held high with 0x11..0x16 on consecutive cycles ->
  - 0x11..0x15 are accepted and the 6th push stalls (ready = 0, fifo_count = 4);
  - 0x16 is accepted the cycle after the second pop;
  - all six frames go out back-to-back with no idle cycles between them.
- Set parity_mode = even at cycle 30 of an 8N1 frame carrying 0x55 -> that frame stays 100 cycles with no parity bit; the next queued frame carries a parity bit.
- Assert reset during data bit 3 with 2 entries queued -> after the reset edge:
  - serial_out = 1, busy = 0, fifo_count = 0, data_in_ready = 1;
  - no further bits appear on the line.
- DATA_BITS = 5, push 0x1F with two_stop, no parity -> 80-cycle frame: 0, 1,1,1,1,1, 1,1.
